attractor_detector: RTL and testbench
=====================================

# attractor_detector

Runs the gene network forward from a given 8-bit initial state and classifies where it ends up: a fixed point or a longer cycle. It uses Brent's cycle-finding algorithm: one network step per clock and no visited-state memory. It sits directly upstream of `init_val_gen`. Its `fixed`/`cycle` pulses and `current_val` drive that block, which returns the next initial value to try. The network's next-state logic is external and combinational: this block presents a state and reads the successor back in the same cycle.

## Interface
- No parameters. State width is fixed at 8 bits.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin evaluation of `init_val`; sampled only in IDLE.
- `init_val`  in  8  initial network state to evaluate.
- `net_next`  in  8  combinational successor of `net_state` from the gene network.
- `net_state`  out  8  state currently presented to the network (hare register).
- `busy`  out  1  high from the cycle after `start` is accepted until the return to IDLE.
- `current_val`  out  8  initial value of the most recent evaluation; held until the next accepted `start`.
- `fixed`  out  1  one-cycle pulse: the attractor is a fixed point.
- `cycle`  out  1  one-cycle pulse: the attractor is a cycle of length ≥2.
- `cycle_len`  out  9  attractor length, 1..256; held until the next accepted `start`.
- `steps`  out  11  number of network steps taken (hare advances); held until the next accepted `start`.

## Operation
- Internal registers:
  - `tortoise[7:0]`
  - `hare[7:0]` (drives `net_state`)
  - `power[9:0]`
  - `lam[9:0]`
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - On `start`=1: `tortoise`←`init_val`, `hare`←`init_val`, `current_val`←`init_val`, `steps`←0, `cycle_len`←0; go to LOAD.
  - Otherwise stay in IDLE.
- LOAD: `hare`←`net_next`, `power`←1, `lam`←1, `steps`←1; go to RUN.
- RUN, when `tortoise`==`hare`: `cycle_len`←`lam[8:0]`; go to DONE.
- RUN, when `tortoise`≠`hare`:
  - If `power`==`lam`: `tortoise`←`hare`, `power`←`power`<<1, `lam`←1.
  - Otherwise: `lam`←`lam`+1.
  - In both cases: `hare`←`net_next`, `steps`←`steps`+1 (saturates at 2047).
- DONE:
  - Assert `fixed`=1 if `cycle_len`==1, else `cycle`=1.
  - Exactly one of the two is high, for exactly one cycle.
  - Next edge: go to IDLE.
- `start` outside IDLE is ignored; it is not queued.
- `init_val` is sampled only on the accepting edge; later changes have no effect on the evaluation in progress.
- Arithmetic:
  - `power` and `lam` are 10 bits; neither exceeds 512 for an 8-bit state space, so no wrap occurs.
  - `cycle_len` is `lam` truncated to 9 bits; its maximum value is 256 (9'h100).

## Timing
- Reset, asynchronous, takes effect immediately, including mid-evaluation:
  - FSM goes to IDLE.
  - `tortoise`, `hare` (so `net_state`), `power`, `lam`, `current_val`, `cycle_len`, `steps` go to 0.
  - `busy`, `fixed`, `cycle` go to 0.
- After reset deasserts, the first `start` is accepted on the next rising edge where it is high.
- `start` accepted at edge k:
  - LOAD is active after edge k.
  - RUN is entered at edge k+1.
- Each RUN cycle performs one comparison and one network step.
- Detection at edge k+1+n means DONE occupies the cycle after that edge, so `fixed`/`cycle` are high during that cycle.
- IDLE is re-entered one edge later. A `start` held high then is accepted on that IDLE cycle's edge.
- Minimum turnaround is 4 cycles (fixed point reached in 0 tail steps).
- `busy` = (state ≠ IDLE).
- `current_val`, `cycle_len` and `steps` are stable while `fixed`/`cycle` pulse. The downstream block samples them during the pulse.
- `net_next` must settle within the same cycle `net_state` changes. There is no extra pipeline stage.

## Test plan
- Identity network (`net_next`=`net_state`), `init_val`=0x05, start pulse:
  - One `fixed` pulse, no `cycle`.
  - `cycle_len`=1, `steps`=1, `current_val`=0x05.
  - `fixed` high in the 3rd cycle after the start edge.
- Toggle network (`net_next`=`net_state`^0x01), `init_val`=0x10:
  - One `cycle` pulse.
  - `cycle_len`=2, `steps`=3.
- Increment network (`net_next`=`net_state`+1 mod 256), `init_val`=0x00:
  - One `cycle` pulse.
  - `cycle_len`=9'h100.
  - `steps` matches a reference Brent model; no counter wrap.
- Tail to fixed point (`net_next`=`net_state`==0 ? 0 : `net_state`−1), `init_val`=0x03:
  - One `fixed` pulse.
  - `cycle_len`=1, `current_val`=0x03.
- Run the toggle network from 0x10, asserting `start` with `init_val`=0x77 mid-RUN:
  - Second `start` ignored.
  - Result as in the toggle scenario.
  - `current_val`=0x10.
- Assert `rst` asynchronously mid-RUN of the increment case:
  - All outputs go to 0 immediately, with no `fixed`/`cycle` pulse.
  - A fresh start with 0x05 on the identity network after reset behaves as in the first scenario.

Source files
------------

// File: rtl/attractor_detector.sv
// Brent cycle finder over an external 8-bit gene network: steps the network
// one state per clock and classifies the attractor as a fixed point or a cycle.
module attractor_detector (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  init_val,
    input  logic [7:0]  net_next,
    output logic [7:0]  net_state,
    output logic        busy,
    output logic [7:0]  current_val,
    output logic        fixed,
    output logic        cycle,
    output logic [8:0]  cycle_len,
    output logic [10:0] steps
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [7:0]  r_tortoise;
    logic [7:0]  r_hare;
    logic [9:0]  r_power;
    logic [9:0]  r_lam;
    logic        r_busy;
    logic        r_fixed;
    logic        r_cycle;
    logic [7:0]  r_current_val;
    logic [8:0]  r_cycle_len;
    logic [10:0] r_steps;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_tortoise    <= '0;
            r_hare        <= '0;
            r_power       <= '0;
            r_lam         <= '0;
            r_busy        <= 1'b0;
            r_fixed       <= 1'b0;
            r_cycle       <= 1'b0;
            r_current_val <= '0;
            r_cycle_len   <= '0;
            r_steps       <= '0;
        end else begin
            // NOTE: pulses default low every edge so DONE's flag lasts exactly one cycle.
            r_fixed <= 1'b0;
            r_cycle <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_tortoise    <= init_val;
                        r_hare        <= init_val;
                        r_current_val <= init_val;
                        r_steps       <= '0;
                        r_cycle_len   <= '0;
                        r_busy        <= 1'b1;
                        r_state       <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_hare  <= net_next;
                    r_power <= 10'd1;
                    r_lam   <= 10'd1;
                    r_steps <= 11'd1;
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    if (r_tortoise == r_hare) begin
                        r_cycle_len <= r_lam[8:0];
                        r_fixed     <= (r_lam == 10'd1);
                        r_cycle     <= (r_lam != 10'd1);
                        r_state     <= S_DONE;
                    end else begin
                        // Brent: at each power-of-two boundary the tortoise teleports to the hare.
                        if (r_power == r_lam) begin
                            r_tortoise <= r_hare;
                            r_power    <= r_power << 1;
                            r_lam      <= 10'd1;
                        end else begin
                            r_lam <= r_lam + 10'd1;
                        end
                        r_hare <= net_next;
                        if (r_steps != 11'h7FF) begin
                            r_steps <= r_steps + 11'd1;
                        end
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign net_state   = r_hare;
    assign busy        = r_busy;
    assign current_val = r_current_val;
    assign fixed       = r_fixed;
    assign cycle       = r_cycle;
    assign cycle_len   = r_cycle_len;
    assign steps       = r_steps;

endmodule

// File: tb/tb_attractor_detector.sv
// Self-checking bench for attractor_detector: directed network table, random
// lookup-table networks against a Brent/visited-set model, mid-run start and reset.
module tb_attractor_detector;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  init_val;
    logic [7:0]  net_next;
    logic [7:0]  net_state;
    logic        busy;
    logic [7:0]  current_val;
    logic        fixed;
    logic        cycle;
    logic [8:0]  cycle_len;
    logic [10:0] steps;

    int total = 0;
    int bad   = 0;
    int mode  = 0;
    logic [7:0] lut [256];

    attractor_detector dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .init_val   (init_val),
        .net_next   (net_next),
        .net_state  (net_state),
        .busy       (busy),
        .current_val(current_val),
        .fixed      (fixed),
        .cycle      (cycle),
        .cycle_len  (cycle_len),
        .steps      (steps)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Network modes: 0 identity, 1 toggle lsb, 2 increment, 3 decrement-to-zero, 4 random table.
    always_comb begin
        case (mode)
            0:       net_next = net_state;
            1:       net_next = net_state ^ 8'h01;
            2:       net_next = net_state + 8'd1;
            3:       net_next = (net_state == 8'd0) ? 8'd0 : net_state - 8'd1;
            default: net_next = lut[net_state];
        endcase
    end

    function automatic logic [7:0] net_f(input int m, input logic [7:0] s);
        case (m)
            0:       return s;
            1:       return s ^ 8'h01;
            2:       return s + 8'd1;
            3:       return (s == 8'd0) ? 8'd0 : s - 8'd1;
            default: return lut[s];
        endcase
    endfunction

    // Attractor length by recording the first visit index of every state.
    function automatic int model_len(input int m, input logic [7:0] init);
        int first [256];
        int i;
        logic [7:0] x;
        for (int k = 0; k < 256; k++) first[k] = -1;
        x = init;
        i = 0;
        while (first[x] < 0) begin
            first[x] = i;
            x = net_f(m, x);
            i++;
        end
        return i - first[x];
    endfunction

    // Textbook Brent: number of hare advances until tortoise meets hare.
    function automatic int model_steps(input int m, input logic [7:0] init);
        logic [7:0] t, h;
        int p, l, s;
        t = init;
        h = net_f(m, init);
        p = 1;
        l = 1;
        s = 1;
        while (t != h) begin
            if (p == l) begin
                t = h;
                p = p * 2;
                l = 0;
            end
            h = net_f(m, h);
            l++;
            s++;
        end
        return (s > 2047) ? 2047 : s;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int         n_fixed;
        int         n_cycle;
        int         pulse_cyc;
        logic       busy1;
        logic [8:0] len;
        logic [10:0] stp;
        logic [7:0] cur;
        logic       timeout;
    } res_t;

    typedef struct {
        int          mode;
        logic [7:0]  init;
        logic        exp_fixed;
        logic [8:0]  exp_len;
        logic [10:0] exp_steps;
    } vec_t;

    // Starts an evaluation and watches it until busy drops after the pulse.
    // glitch_cyc > 0 raises start with 0x77 during that cycle of the evaluation.
    task automatic run_eval(input int mode_i, input logic [7:0] init_i, input int glitch_cyc,
                            output res_t r);
        int  n;
        bit  done;
        r = '{default: 0};
        mode = mode_i;
        @(negedge clk);
        init_val = init_i;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n     = 1;
        done  = 0;
        r.busy1 = busy;
        while (!done && n < 5000) begin
            if (n == glitch_cyc) begin
                start    = 1'b1;
                init_val = 8'h77;
            end else begin
                start = 1'b0;
            end
            if (fixed || cycle) begin
                if (r.n_fixed + r.n_cycle == 0) begin
                    r.pulse_cyc = n;
                    r.len       = cycle_len;
                    r.stp       = steps;
                    r.cur       = current_val;
                end
                if (fixed) r.n_fixed++;
                if (cycle) r.n_cycle++;
            end
            if (!busy && (r.n_fixed + r.n_cycle) > 0) begin
                done = 1;
            end else begin
                @(negedge clk);
                n++;
            end
        end
        start = 1'b0;
        r.timeout = !done;
    endtask

    task automatic check_result(input string tag, input res_t r, input logic exp_fixed,
                                input logic [8:0] exp_len, input logic [10:0] exp_steps,
                                input logic [7:0] exp_cur);
        check({tag, " timeout"},   32'(r.timeout), 32'd0);
        check({tag, " busy"},      32'(r.busy1), 32'd1);
        check({tag, " n_fixed"},   32'(r.n_fixed), exp_fixed ? 32'd1 : 32'd0);
        check({tag, " n_cycle"},   32'(r.n_cycle), exp_fixed ? 32'd0 : 32'd1);
        check({tag, " cycle_len"}, 32'(r.len), 32'(exp_len));
        check({tag, " steps"},     32'(r.stp), 32'(exp_steps));
        check({tag, " cur_val"},   32'(r.cur), 32'(exp_cur));
        check({tag, " latency"},   32'(r.pulse_cyc), 32'(exp_steps) + 32'd2);
    endtask

    initial begin
        vec_t vecs [4];
        res_t r;
        logic [7:0] rinit;
        int   elen;

        vecs[0] = '{mode: 0, init: 8'h05, exp_fixed: 1'b1, exp_len: 9'd1,   exp_steps: 11'd1};
        vecs[1] = '{mode: 1, init: 8'h10, exp_fixed: 1'b0, exp_len: 9'd2,   exp_steps: 11'd3};
        vecs[2] = '{mode: 2, init: 8'h00, exp_fixed: 1'b0, exp_len: 9'h100, exp_steps: 11'd0};
        vecs[3] = '{mode: 3, init: 8'h03, exp_fixed: 1'b1, exp_len: 9'd1,   exp_steps: 11'd4};
        vecs[2].exp_steps = 11'(model_steps(2, 8'h00));

        for (int k = 0; k < 256; k++) lut[k] = 8'(k);
        rst      = 1'b1;
        start    = 1'b0;
        init_val = 8'h00;
        #12;
        check("reset net_state", 32'(net_state), 32'd0);
        check("reset busy",      32'(busy), 32'd0);
        check("reset flags",     32'({fixed, cycle}), 32'd0);
        check("reset cur/len/steps", 32'({current_val, cycle_len, steps}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 4; v++) begin
            run_eval(vecs[v].mode, vecs[v].init, 0, r);
            check_result($sformatf("vec%0d", v), r, vecs[v].exp_fixed, vecs[v].exp_len,
                         vecs[v].exp_steps, vecs[v].init);
        end

        // Start raised with a different init_val during RUN must be ignored.
        run_eval(1, 8'h10, 3, r);
        check_result("ignored_start", r, 1'b0, 9'd2, 11'd3, 8'h10);
        repeat (2) @(negedge clk);
        check("no requeue busy", 32'(busy), 32'd0);

        // Random table-driven networks against the model.
        for (int t = 0; t < 20; t++) begin
            for (int k = 0; k < 256; k++) lut[k] = 8'($urandom_range(0, 255));
            if (t < 3) lut[8'(t)] = 8'(t);
            rinit = (t < 3) ? 8'(t) : 8'($urandom_range(0, 255));
            elen  = model_len(4, rinit);
            run_eval(4, rinit, 0, r);
            check_result($sformatf("rand%0d", t), r, elen == 1, 9'(elen),
                         11'(model_steps(4, rinit)), rinit);
        end

        // Asynchronous reset in the middle of the increment run.
        mode = 2;
        @(negedge clk);
        init_val = 8'h00;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        check("pre-reset busy", 32'(busy), 32'd1);
        check("pre-reset steps nonzero", 32'(steps != 11'd0), 32'd1);
        #3 rst = 1'b1;
        #1;
        check("async net_state", 32'(net_state), 32'd0);
        check("async busy",      32'(busy), 32'd0);
        check("async flags",     32'({fixed, cycle}), 32'd0);
        check("async cur/len/steps", 32'({current_val, cycle_len, steps}), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("reset hold quiet", 32'({busy, fixed, cycle}), 32'd0);
        end
        rst = 1'b0;
        run_eval(0, 8'h05, 0, r);
        check_result("post_reset", r, 1'b1, 9'd1, 11'd1, 8'h05);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
